// File: rtl/param_lifo_if.sv
// Bus bundle for param_lifo: request/data inputs from the user side and the
// registered pop result, peek and status flags from the stack side.
interface param_lifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic             clear_err;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, data_in, clear_err,
    input  data_out, out_valid, top, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, data_in, clear_err,
    output data_out, out_valid, top, count, empty, full, overflow, underflow
  );

endinterface

// File: rtl/param_lifo.sv
// Parameterized register-based LIFO stack. Entries 0..count-1 are live, the
// top of stack lives at index count-1. Pops return data one cycle later on
// data_out/out_valid; top is a zero-latency peek. Simultaneous push+pop swaps
// the top entry (or bypasses data_in straight through when empty). Overflow
// and underflow are sticky until clear_err.
module param_lifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  param_lifo_if.slave    bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Saturating occupancy increment: never exceeds DEPTH.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (c >= CW'(DEPTH)) return c;
    return c + CW'(1);
  endfunction

  // Saturating occupancy decrement: never goes below zero.
  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] c);
    if (c == '0) return c;
    return c - CW'(1);
  endfunction

  // Narrow an occupancy value down to a storage index.
  function automatic logic [AW-1:0] to_idx(input logic [CW-1:0] c);
    return AW'(c);
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] data_out_p1;
  logic             vld_p1;
  logic             ovf_q;
  logic             udf_q;

  logic             is_empty;
  logic             is_full;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             push_only;
  logic             pop_only;
  logic             swap;
  logic             bypass;
  logic             ovf_evt;
  logic             udf_evt;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  // Wraps when empty; every consumer is gated by is_empty so that is harmless.
  assign top_idx  = to_idx(count_q - CW'(1));

  // Decode the request mix into mutually exclusive operations.
  always_comb begin
    push_only = 1'b0;
    pop_only  = 1'b0;
    swap      = 1'b0;
    bypass    = 1'b0;
    ovf_evt   = 1'b0;
    udf_evt   = 1'b0;
    if (bus.push && bus.pop) begin
      swap   = !is_empty;
      bypass = is_empty;
    end else if (bus.push) begin
      push_only = !is_full;
      ovf_evt   = is_full;
    end else if (bus.pop) begin
      pop_only = !is_empty;
      udf_evt  = is_empty;
    end
  end

  // Write port, read data selection and next occupancy.
  always_comb begin
    wr_en     = push_only || swap;
    wr_idx    = swap ? top_idx : to_idx(count_q);
    rd_en     = pop_only || swap || bypass;
    rd_data   = bypass ? bus.data_in : mem[top_idx];
    count_nxt = count_q;
    if (push_only)     count_nxt = sat_inc(count_q);
    else if (pop_only) count_nxt = sat_dec(count_q);
  end

  // Storage array: not reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wr_idx] <= bus.data_in;
  end

  // Occupancy, registered pop result and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      data_out_p1 <= '0;
      vld_p1      <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      count_q <= count_nxt;
      if (rd_en) data_out_p1 <= rd_data;
      vld_p1  <= rd_en;
      // A fresh error in the same cycle as clear_err keeps the flag set.
      ovf_q   <= ovf_evt || (ovf_q && !bus.clear_err);
      udf_q   <= udf_evt || (udf_q && !bus.clear_err);
    end
  end

  assign bus.data_out  = data_out_p1;
  assign bus.out_valid = vld_p1;
  assign bus.top       = is_empty ? '0 : mem[top_idx];
  assign bus.count     = count_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;

endmodule

// File: tb/tb_param_lifo.sv
// Bench for param_lifo (WIDTH=8, DEPTH=4): directed scenarios followed by
// randomized traffic, all compared against a queue-based stack model.
module tb_param_lifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk;
  logic reset;

  param_lifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) bus ();

  param_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [WIDTH-1:0] stk[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_vld;
  logic             m_ovf;
  logic             m_udf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic rs, input logic ps, input logic pp,
                            input logic [WIDTH-1:0] d, input logic cl);
    logic new_ovf;
    logic new_udf;
    new_ovf = 1'b0;
    new_udf = 1'b0;
    if (rs) begin
      stk.delete();
      m_dout = '0;
      m_vld  = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      m_vld = 1'b0;
      if (ps && pp) begin
        if (stk.size() == 0) begin
          m_dout = d;
        end else begin
          m_dout = stk.pop_back();
          stk.push_back(d);
        end
        m_vld = 1'b1;
      end else if (ps) begin
        if (stk.size() == DEPTH) new_ovf = 1'b1;
        else stk.push_back(d);
      end else if (pp) begin
        if (stk.size() == 0) new_udf = 1'b1;
        else begin
          m_dout = stk.pop_back();
          m_vld  = 1'b1;
        end
      end
      m_ovf = new_ovf ? 1'b1 : (cl ? 1'b0 : m_ovf);
      m_udf = new_udf ? 1'b1 : (cl ? 1'b0 : m_udf);
    end
  endtask

  task automatic check_all();
    logic [WIDTH-1:0] exp_top;
    exp_top = (stk.size() > 0) ? stk[stk.size()-1] : '0;
    check_eq("data_out",  32'(bus.data_out),  32'(m_dout));
    check_eq("out_valid", 32'(bus.out_valid), 32'(m_vld));
    check_eq("top",       32'(bus.top),       32'(exp_top));
    check_eq("count",     32'(bus.count),     32'(stk.size()));
    check_eq("empty",     32'(bus.empty),     32'(stk.size() == 0));
    check_eq("full",      32'(bus.full),      32'(stk.size() == DEPTH));
    check_eq("overflow",  32'(bus.overflow),  32'(m_ovf));
    check_eq("underflow", 32'(bus.underflow), 32'(m_udf));
  endtask

  task automatic step(input logic rs, input logic ps, input logic pp,
                      input logic [WIDTH-1:0] d, input logic cl);
    reset         = rs;
    bus.push      = ps;
    bus.pop       = pp;
    bus.data_in   = d;
    bus.clear_err = cl;
    @(posedge clk);
    model_step(rs, ps, pp, d, cl);
    #1;
    check_all();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] pops [4];
    pops[0] = 8'h44; pops[1] = 8'h33; pops[2] = 8'h22; pops[3] = 8'h11;

    reset = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0; bus.clear_err = 1'b0;

    // Reset state.
    step(1, 0, 0, 8'h00, 0);
    check_eq("rst_empty", 32'(bus.empty), 32'd1);
    check_eq("rst_count", 32'(bus.count), 32'd0);

    // Fill to full.
    step(0, 1, 0, 8'h11, 0);
    step(0, 1, 0, 8'h22, 0);
    step(0, 1, 0, 8'h33, 0);
    step(0, 1, 0, 8'h44, 0);
    check_eq("fill_full", 32'(bus.full), 32'd1);
    check_eq("fill_top",  32'(bus.top),  32'h44);

    // Overflow, then clear.
    step(0, 1, 0, 8'h55, 0);
    check_eq("ovf_flag",  32'(bus.overflow), 32'd1);
    check_eq("ovf_top",   32'(bus.top),      32'h44);
    step(0, 0, 0, 8'h00, 1);
    check_eq("ovf_clear", 32'(bus.overflow), 32'd0);

    // Drain in LIFO order.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 8'h00, 0);
      check_eq("pop_data", 32'(bus.data_out),  32'(pops[i]));
      check_eq("pop_vld",  32'(bus.out_valid), 32'd1);
    end
    check_eq("drain_empty", 32'(bus.empty), 32'd1);

    // Underflow, then bypass while empty.
    step(0, 0, 1, 8'h00, 0);
    check_eq("udf_flag", 32'(bus.underflow), 32'd1);
    check_eq("udf_hold", 32'(bus.data_out),  32'h11);
    step(0, 1, 1, 8'hA5, 0);
    check_eq("byp_data",  32'(bus.data_out),  32'hA5);
    check_eq("byp_count", 32'(bus.count),     32'd0);
    check_eq("byp_vld",   32'(bus.out_valid), 32'd1);
    step(0, 0, 0, 8'h00, 1);

    // Swap on a partially filled stack, then on a full one.
    step(0, 1, 0, 8'h11, 0);
    step(0, 1, 0, 8'h22, 0);
    step(0, 1, 1, 8'h99, 0);
    check_eq("swap_data", 32'(bus.data_out), 32'h22);
    check_eq("swap_top",  32'(bus.top),      32'h99);
    step(0, 1, 0, 8'h33, 0);
    step(0, 1, 0, 8'h44, 0);
    step(0, 1, 1, 8'h77, 0);
    check_eq("swapf_ovf",   32'(bus.overflow), 32'd0);
    check_eq("swapf_count", 32'(bus.count),    32'd4);

    // Reset mid-sequence with push asserted.
    step(0, 0, 1, 8'h00, 0);
    check_eq("pre_rst_cnt", 32'(bus.count), 32'd3);
    step(1, 1, 0, 8'hEE, 1);
    check_eq("mid_rst_cnt", 32'(bus.count),     32'd0);
    check_eq("mid_rst_vld", 32'(bus.out_valid), 32'd0);
    step(0, 0, 1, 8'h00, 0);
    check_eq("post_rst_udf", 32'(bus.underflow), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic rs, ps, pp, cl;
      logic [WIDTH-1:0] d;
      rs = ($urandom_range(0, 99) < 2);
      ps = ($urandom_range(0, 99) < 55);
      pp = ($urandom_range(0, 99) < 45);
      cl = ($urandom_range(0, 99) < 10);
      d  = WIDTH'($urandom);
      step(rs, ps, pp, d, cl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_lifo.md
PARAM_LIFO -- requirements
Module: param_lifo

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of stack entries (>=2).
REQ-003 Parameter CW, default $clog2(DEPTH+1), width of the occupancy count.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 push  input  1  write request for data_in this cycle.
REQ-007 pop  input  1  read request for top entry this cycle.
REQ-008 data_in  input  WIDTH  word to push.
REQ-009 clear_err  input  1  clears sticky error flags.
REQ-010 data_out  output  WIDTH  registered popped word.
REQ-011 out_valid  output  1  registered; high one cycle when data_out updated by a pop.
REQ-012 top  output  WIDTH  combinational peek of top entry; 0 when empty.
REQ-013 count  output  CW  current occupancy, 0..DEPTH.
REQ-014 empty  output  1  combinational, high when count==0.
REQ-015 full  output  1  combinational, high when count==DEPTH.
REQ-016 overflow  output  1  sticky; push rejected while full.
REQ-017 underflow  output  1  sticky; pop rejected while empty.

Function
REQ-018 Storage SHALL be DEPTH x WIDTH registers indexed 0..DEPTH-1; top entry is index count-1.
REQ-019 Push only, not full: mem[count] <= data_in, count += 1; out_valid 0.
REQ-020 Pop only, not empty: data_out <= mem[count-1], out_valid 1 next cycle, count -= 1 (one-cycle latency).
REQ-021 Push+pop, not empty (including full): data_out <= mem[count-1], mem[count-1] <= data_in, count unchanged, out_valid 1.
REQ-022 Push+pop, empty: bypass, data_out <= data_in, out_valid 1, count stays 0, no underflow.
REQ-023 Push only while full: write ignored, storage and count unchanged, overflow set.
REQ-024 Pop only while empty: data_out holds, out_valid 0, underflow set.
REQ-025 No pop accepted: data_out SHALL hold its previous value; out_valid 0.
REQ-026 count SHALL never wrap: no increment above DEPTH, no decrement below 0.
REQ-027 clear_err clears overflow and underflow next edge; a new error in the same cycle wins (flag remains 1).
REQ-028 top SHALL equal mem[count-1] when count>0, else 0, with no added latency.

Reset
REQ-029 reset sampled high: count 0, data_out 0, out_valid 0, overflow 0, underflow 0; empty 1, full 0 thereafter.
REQ-030 Storage contents are not cleared by reset; entries are unreadable until re-pushed.
REQ-031 reset has priority over push, pop and clear_err in the same cycle, including mid-sequence.

Verification (WIDTH=8, DEPTH=4)
REQ-032 Reset, then push 0x11,0x22,0x33,0x44 -> count 1,2,3,4; full=1 after 4th; top=0x44.
REQ-033 Full, push 0x55 -> count 4, overflow=1, top 0x44; then clear_err -> overflow 0.
REQ-034 Pop x4 from REQ-032 state -> data_out 0x44,0x33,0x22,0x11 each with out_valid=1 one cycle after pop; empty=1 at end.
REQ-035 Empty, pop -> underflow=1, out_valid=0, data_out holds 0x11; push+pop 0xA5 while empty -> data_out 0xA5, out_valid 1, count 0.
REQ-036 count=2 (0x11,0x22), push+pop 0x99 -> data_out 0x22, top 0x99, count 2; full stack push+pop -> no overflow, count 4.
REQ-037 count=3, assert reset with push=1 -> count 0, empty 1, out_valid 0, flags 0; next pop -> underflow=1.
